// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
// The SDRAM_ARB_FIXED_PRIO_EN build option lives in sdram_arbiter.sv.
package sdram_arb_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational grant selection between the CPU and DMA ports.
// A lone requester always wins; a tie goes to the port not served last.
module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o
);

    always_comb begin
        grant_o = PORT_CPU;
        case (req_i)
            2'b10:   grant_o = PORT_DMA;
            2'b11:   grant_o = ~last_i;
            default: grant_o = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-master (CPU/DMA) arbiter in front of a single-request SDRAM controller.
// Define SDRAM_ARB_FIXED_PRIO_EN to make the CPU win every tie (no round-robin pointer).
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p0_d,
    input  logic [DATA_W-1:0] p1_d,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic              p0_start,
    input  logic              p1_start,
    output logic [DATA_W-1:0] p0_q,
    output logic [DATA_W-1:0] p1_q,
    output logic              p0_done,
    output logic              p1_done,
    output logic [ADDR_W-1:0] sdc_addr,
    output logic [DATA_W-1:0] sdc_d,
    output logic              sdc_we,
    output logic              sdc_start,
    input  logic [DATA_W-1:0] sdc_q,
    input  logic              sdc_q_ready,
    input  logic              sdc_busy,
    input  logic              sdc_init_done,
    output arb_state_e        dbg_state
);

    arb_state_e        state_q;
    logic              grant_q;
    logic [ADDR_W-1:0] sdc_addr_q;
    logic [DATA_W-1:0] sdc_d_q;
    logic              sdc_we_q;
    logic              sdc_start_q;
    logic [DATA_W-1:0] p0_q_q;
    logic [DATA_W-1:0] p1_q_q;
    logic              p0_done_q;
    logic              p1_done_q;
    logic              grant;
    logic              last_served;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    // Pretending DMA was always served last makes every tie go to the CPU.
    assign last_served = PORT_DMA;
`else
    logic last_q;
    assign last_served = last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_q <= PORT_DMA;
        else if (state_q == ISSUE && sdc_q_ready)
            last_q <= grant_q;
    end
`endif

    sdram_arb_pick u_pick (
        .req_i   ({p1_start, p0_start}),
        .last_i  (last_served),
        .grant_o (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= PORT_CPU;
            sdc_addr_q  <= '0;
            sdc_d_q     <= '0;
            sdc_we_q    <= 1'b0;
            sdc_start_q <= 1'b0;
            p0_q_q      <= '0;
            p1_q_q      <= '0;
            p0_done_q   <= 1'b0;
            p1_done_q   <= 1'b0;
        end else begin
            p0_done_q <= 1'b0;
            p1_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Refresh or init in progress holds every grant off.
                    if (sdc_init_done && !sdc_busy && (p0_start || p1_start)) begin
                        grant_q     <= grant;
                        sdc_addr_q  <= (grant == PORT_DMA) ? p1_addr : p0_addr;
                        sdc_d_q     <= (grant == PORT_DMA) ? p1_d    : p0_d;
                        sdc_we_q    <= (grant == PORT_DMA) ? p1_we   : p0_we;
                        sdc_start_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sdc_q_ready) begin
                        sdc_start_q <= 1'b0;
                        state_q     <= RELEASE;
                        if (grant_q == PORT_DMA) begin
                            p1_done_q <= 1'b1;
                            if (!sdc_we_q)
                                p1_q_q <= sdc_q;
                        end else begin
                            p0_done_q <= 1'b1;
                            if (!sdc_we_q)
                                p0_q_q <= sdc_q;
                        end
                    end
                end
                RELEASE: begin
                    if (!sdc_busy)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sdc_addr  = sdc_addr_q;
    assign sdc_d     = sdc_d_q;
    assign sdc_we    = sdc_we_q;
    assign sdc_start = sdc_start_q;
    assign p0_q      = p0_q_q;
    assign p1_q      = p1_q_q;
    assign p0_done   = p0_done_q;
    assign p1_done   = p1_done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: behavioural controller, transaction-level scoreboard,
// directed table, multi-cycle corner sequences and randomized two-master traffic.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic [23:0] p0_addr, p1_addr;
    logic [31:0] p0_d, p1_d;
    logic        p0_we, p1_we, p0_start, p1_start;
    logic [31:0] p0_q, p1_q;
    logic        p0_done, p1_done;
    logic [23:0] sdc_addr;
    logic [31:0] sdc_d;
    logic        sdc_we, sdc_start;
    logic [31:0] sdc_q;
    logic        sdc_q_ready, sdc_busy, sdc_init_done;
    arb_state_e  dbg_state;

    logic        force_busy, mdl_busy, init_r;
    int          ctl_lat;
    int          n_checks, n_pass;

    assign sdc_busy      = force_busy | mdl_busy;
    assign sdc_init_done = init_r;

    sdram_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_d(p0_d), .p1_d(p1_d),
        .p0_we(p0_we), .p1_we(p1_we), .p0_start(p0_start), .p1_start(p1_start),
        .p0_q(p0_q), .p1_q(p1_q), .p0_done(p0_done), .p1_done(p1_done),
        .sdc_addr(sdc_addr), .sdc_d(sdc_d), .sdc_we(sdc_we), .sdc_start(sdc_start),
        .sdc_q(sdc_q), .sdc_q_ready(sdc_q_ready), .sdc_busy(sdc_busy),
        .sdc_init_done(sdc_init_done), .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference memory seen by the behavioural controller.
    logic [31:0] mem [logic [23:0]];

    function automatic logic [31:0] ref_rd(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return {8'h5A, a};
    endfunction

    // Which master the rules say should win, given who requested and who was served last.
    function automatic logic pick_ref(input logic r0, input logic r1, input logic last);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        if (r0) return 1'b0;
        return last | r1;
`else
        if (r0 && r1) return !last;
        return r1 && !r0;
`endif
    endfunction

    // Behavioural SDRAM controller: busy from accept until after the response.
    logic [23:0] c_addr;
    logic [31:0] c_d;
    logic        c_we;
    int          c_n;
    initial begin
        sdc_q = '0; sdc_q_ready = 1'b0; mdl_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (sdc_start) begin
                c_addr = sdc_addr; c_d = sdc_d; c_we = sdc_we;
                mdl_busy = 1'b1;
                c_n = (ctl_lat != 0) ? ctl_lat : int'($urandom_range(1, 4));
                repeat (c_n - 1) begin @(posedge clk); #1; end
                if (c_we) begin
                    mem[c_addr] = c_d;
                    sdc_q = $urandom;
                end else begin
                    sdc_q = ref_rd(c_addr);
                end
                sdc_q_ready = 1'b1;
                @(posedge clk); #1;
                sdc_q_ready = 1'b0;
                for (int c = 0; c < 100 && sdc_start; c++) begin @(posedge clk); #1; end
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                mdl_busy = 1'b0;
            end
        end
    end

    // Transaction scoreboard, sampled on the falling edge.
    logic        inflight, e_w, e_we, mdl_last, due, w;
    logic [23:0] e_addr;
    logic [31:0] e_d, mdl_q0, mdl_q1;
    logic        pv_start, pv_ready, pv_busy, pv_init, pv_r0, pv_r1;
    logic        grant_log [$];
    logic [0:0]  exp_q [$];

    always @(negedge clk) begin
        if (reset) begin
            inflight = 1'b0; mdl_last = 1'b1; mdl_q0 = '0; mdl_q1 = '0;
            pv_start = 1'b0; pv_ready = 1'b0; pv_busy = 1'b0; pv_init = 1'b0;
            pv_r0 = 1'b0; pv_r1 = 1'b0;
        end else begin
            due = inflight && pv_start && pv_ready;
            if (sdc_start && !pv_start) begin
                chk("issue_cond", {61'd0, pv_init, pv_busy, pv_r0 | pv_r1}, 64'b101);
                w      = pick_ref(pv_r0, pv_r1, mdl_last);
                e_w    = w;
                e_addr = w ? p1_addr : p0_addr;
                e_d    = w ? p1_d : p0_d;
                e_we   = w ? p1_we : p0_we;
                chk("issue_req", {sdc_we, sdc_addr, sdc_d}, {e_we, e_addr, e_d});
                inflight = 1'b1;
            end else if (inflight && pv_start && !pv_ready) begin
                chk("issue_hold", {sdc_start, sdc_we, sdc_addr, sdc_d}, {1'b1, e_we, e_addr, e_d});
            end
            if (due) begin
                chk("done_pulse", {p1_done, p0_done}, e_w ? 64'b10 : 64'b01);
                chk("start_gap", sdc_start, 1'b0);
                if (!e_we) begin
                    if (e_w) mdl_q1 = ref_rd(e_addr);
                    else     mdl_q0 = ref_rd(e_addr);
                end
                mdl_last = e_w;
                grant_log.push_back(e_w);
                inflight = 1'b0;
            end else begin
                chk("no_done", {p1_done, p0_done}, 64'b00);
            end
            chk("q_regs", {p1_q, p0_q}, {mdl_q1, mdl_q0});
            pv_start = sdc_start; pv_ready = sdc_q_ready; pv_busy = sdc_busy;
            pv_init = sdc_init_done; pv_r0 = p0_start; pv_r1 = p1_start;
        end
    end

    task automatic drive_port(input int p, input logic [23:0] a, input logic [31:0] dd, input logic we);
        if (p == 0) begin p0_addr = a; p0_d = dd; p0_we = we; p0_start = 1'b1; end
        else        begin p1_addr = a; p1_d = dd; p1_we = we; p1_start = 1'b1; end
    endtask

    task automatic set_start(input int p, input logic s);
        if (p == 0) p0_start = s;
        else        p1_start = s;
    endtask

    task automatic wait_done(input int p, input int lim, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < lim && !ok; c++) begin
            @(negedge clk);
            ok = (p == 0) ? p0_done : p1_done;
        end
    endtask

    task automatic wait_rise(input int lim, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < lim && !ok; c++) begin
            @(negedge clk);
            ok = sdc_start;
        end
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = (dbg_state == IDLE) && !sdc_busy && !sdc_start;
        end
        chk("wait_idle", ok, 1'b1);
    endtask

    task automatic port_traffic(input int p, input int n);
        logic ok, keep;
        keep = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!keep) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            drive_port(p, 24'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
            wait_done(p, 300, ok);
            chk("rand_done", ok, 1'b1);
            @(posedge clk); #1;
            keep = (i < n - 1) && ($urandom_range(0, 1) == 1);
            if (!keep) set_start(p, 1'b0);
        end
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [23:0] addr;
        logic [31:0] d;
        logic        pre;
        logic [31:0] pdata;
        logic [31:0] eq0;
        logic [31:0] eq1;
    } vec_t;
    vec_t tbl [6];

    initial begin
        logic ok, held, a0, a1, d0, d1;
        int   n;

        tbl[0] = '{1'b0, 1'b0, 24'h000010, 32'h1111_0000, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 24'h00ABCD, 32'h12345678, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 24'h00ABCD, 32'h1111_0002, 1'b0, 32'h0, 32'hDEADBEEF, 32'h12345678};
        tbl[3] = '{1'b0, 1'b1, 24'h000010, 32'hCAFEF00D, 1'b0, 32'h0, 32'hDEADBEEF, 32'h12345678};
        tbl[4] = '{1'b0, 1'b0, 24'h000010, 32'h1111_0004, 1'b0, 32'h0, 32'hCAFEF00D, 32'h12345678};
        tbl[5] = '{1'b1, 1'b0, 24'hFFFFFF, 32'h1111_0005, 1'b1, 32'h0BADF00D, 32'hCAFEF00D, 32'h0BADF00D};

        n_checks = 0; n_pass = 0; ctl_lat = 0;
        reset = 1'b1; init_r = 1'b1; force_busy = 1'b0;
        p0_addr = '0; p1_addr = '0; p0_d = '0; p1_d = '0;
        p0_we = 1'b0; p1_we = 1'b0; p0_start = 1'b0; p1_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {sdc_start, sdc_we, sdc_addr, sdc_d}, 64'd0);
        chk("rst_q", {p1_q, p0_q}, 64'd0);
        chk("rst_done", {p1_done, p0_done}, 64'd0);
        chk("rst_fsm", dbg_state, IDLE);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed single-master transactions.
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            if (tbl[i].pre) mem[tbl[i].addr] = tbl[i].pdata;
            @(posedge clk); #1;
            drive_port(int'(tbl[i].port), tbl[i].addr, tbl[i].d, tbl[i].we);
            @(negedge clk);
            chk("lat_pre", sdc_start, 1'b0);
            @(negedge clk);
            chk("lat_rise", sdc_start, 1'b1);
            chk("tbl_req", {sdc_we, sdc_addr, sdc_d}, {tbl[i].we, tbl[i].addr, tbl[i].d});
            wait_done(int'(tbl[i].port), 50, ok);
            chk("tbl_done", ok, 1'b1);
            chk("tbl_other", tbl[i].port ? p0_done : p1_done, 1'b0);
            chk("tbl_q", {p1_q, p0_q}, {tbl[i].eq1, tbl[i].eq0});
            @(posedge clk); #1;
            set_start(int'(tbl[i].port), 1'b0);
            @(negedge clk);
            chk("tbl_pulse1", {p1_done, p0_done}, 64'b00);
        end

        // Both masters request continuously; record completion order.
        wait_idle();
        grant_log.delete();
        @(posedge clk); #1;
        drive_port(0, 24'h000020, 32'h0, 1'b0);
        drive_port(1, 24'h000021, 32'h0, 1'b0);
        n = 0; a0 = 1'b1; a1 = 1'b1;
        for (int c = 0; c < 400 && (a0 || a1); c++) begin
            @(negedge clk);
            d0 = p0_done; d1 = p1_done;
            if (d0 || d1) n++;
            @(posedge clk); #1;
            if (d0 && n >= 4) begin p0_start = 1'b0; a0 = 1'b0; end
            if (d1 && n >= 4) begin p1_start = 1'b0; a1 = 1'b0; end
        end
        chk("tie_finish", {a1, a0}, 64'b00);
        exp_q.delete();
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
`else
        exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
`endif
        chk("tie_count", grant_log.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++)
            if (i < grant_log.size()) chk("tie_order", grant_log[i], exp_q[i]);

        // Controller still initialising: request must wait.
        wait_idle();
        init_r = 1'b0;
        @(posedge clk); #1;
        drive_port(0, 24'h000030, 32'h0, 1'b0);
        held = 1'b1;
        repeat (50) begin @(negedge clk); if (sdc_start) held = 1'b0; end
        chk("init_hold", held, 1'b1);
        @(posedge clk); #1;
        init_r = 1'b1;
        wait_rise(4, ok);
        chk("init_issue", ok, 1'b1);
        wait_done(0, 50, ok);
        chk("init_done", ok, 1'b1);
        @(posedge clk); #1;
        p0_start = 1'b0;

        // Refresh in progress: request must wait.
        wait_idle();
        @(posedge clk); #1;
        force_busy = 1'b1;
        drive_port(0, 24'h000031, 32'h0, 1'b0);
        held = 1'b1;
        repeat (6) begin @(negedge clk); if (sdc_start) held = 1'b0; end
        chk("busy_hold", held, 1'b1);
        @(posedge clk); #1;
        force_busy = 1'b0;
        wait_rise(4, ok);
        chk("busy_issue", ok, 1'b1);
        wait_done(0, 50, ok);
        chk("busy_done", ok, 1'b1);
        @(posedge clk); #1;
        p0_start = 1'b0;

        // Reset in the middle of a transaction while the controller stays busy.
        wait_idle();
        ctl_lat = 12;
        @(posedge clk); #1;
        drive_port(0, 24'h000055, 32'h0, 1'b0);
        wait_rise(4, ok);
        chk("mid_issue", ok, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1; force_busy = 1'b1;
        #1;
        chk("mid_rst_start", sdc_start, 1'b0);
        chk("mid_rst_req", {sdc_we, sdc_addr, sdc_d}, 64'd0);
        chk("mid_rst_q", {p1_q, p0_q}, 64'd0);
        chk("mid_rst_done", {p1_done, p0_done}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        held = 1'b1;
        repeat (5) begin @(negedge clk); if (sdc_start || p0_done) held = 1'b0; end
        chk("mid_busy_hold", held, 1'b1);
        @(posedge clk); #1;
        force_busy = 1'b0; ctl_lat = 0;
        wait_rise(60, ok);
        chk("mid_reissue", ok, 1'b1);
        wait_done(0, 50, ok);
        chk("mid_done", ok, 1'b1);
        @(posedge clk); #1;
        p0_start = 1'b0;

        // Randomized concurrent traffic with random refresh windows.
        wait_idle();
        fork
            port_traffic(0, 20);
            port_traffic(1, 20);
            begin
                repeat (300) begin
                    @(posedge clk); #1;
                    force_busy = ($urandom_range(0, 9) == 0);
                end
                force_busy = 1'b0;
            end
        join
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
